// File: rtl/soda_datapath.sv
`default_nettype none
// soda_datapath -- saturating coin total, price compare and paced change payout (rev 1.0)
module soda_datapath #(
  parameter int WIDTH       = 8,
  parameter int PRICE       = 25,
  parameter int CHANGE_UNIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             tc,
  input  logic             tw,
  input  logic             d,
  output logic             tm,
  output logic [WIDTH-1:0] tot,
  output logic             ovf,
  output logic             chg_pulse,
  output logic             chg_busy,
  output logic             chg_done,
  output logic [WIDTH-1:0] chg_left
);

  localparam logic [WIDTH-1:0] c_PRICE = WIDTH'(PRICE);
  localparam logic [WIDTH-1:0] c_UNIT  = WIDTH'(CHANGE_UNIT);
  localparam logic [WIDTH-1:0] c_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_tot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_chg_left;
  logic             r_ovf;
  logic             r_d_prev;
  logic             r_phase;
  logic             w_d_rise;
  logic             w_can_pay;
  logic             w_pulse;
  logic             w_done;
  logic [WIDTH:0]   w_sum;

  assign w_d_rise  = d & ~r_d_prev;
  assign w_sum     = {1'b0, r_tot} + {1'b0, a};
  assign w_can_pay = (r_rem >= c_UNIT);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Pulse/done are gated by tc so an abort never shows a strobe in its own cycle.
  always_comb begin
    w_next  = r_state;
    w_pulse = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: if (!tc && w_d_rise) w_next = ST_PAY;
      ST_PAY: begin
        if (tc) begin
          w_next = ST_IDLE;
        end else if (!r_phase) begin
          if (w_can_pay) begin
            w_pulse = 1'b1;
          end else begin
            w_done = 1'b1;
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE: if (tc) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tot      <= '0;
      r_ovf      <= 1'b0;
      r_d_prev   <= 1'b0;
      r_rem      <= '0;
      r_phase    <= 1'b0;
      r_chg_left <= '0;
    end else begin
      r_d_prev <= d;
      if (tc) begin
        r_tot <= '0;
        r_ovf <= 1'b0;
      end else if (tw && r_state == ST_IDLE) begin
        if (w_sum[WIDTH]) begin
          r_tot <= c_MAX;
          r_ovf <= 1'b1;
        end else begin
          r_tot <= w_sum[WIDTH-1:0];
        end
      end
      if (r_state == ST_IDLE && w_next == ST_PAY) begin
        r_rem      <= (r_tot >= c_PRICE) ? (r_tot - c_PRICE) : '0;
        r_phase    <= 1'b0;
        r_chg_left <= '0;
      end else if (r_state == ST_PAY) begin
        if (w_pulse) begin
          r_rem   <= r_rem - c_UNIT;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
        end
        if (w_done) r_chg_left <= r_rem;
      end
    end
  end

  assign tm        = (r_tot >= c_PRICE);
  assign tot       = r_tot;
  assign ovf       = r_ovf;
  assign chg_pulse = w_pulse;
  assign chg_busy  = (r_state == ST_PAY);
  assign chg_done  = w_done;
  assign chg_left  = r_chg_left;

endmodule
`default_nettype wire

// File: tb/tb_soda_datapath.sv
`default_nettype none
// tb_soda_datapath -- directed vector table plus hand-written payout/abort sequences
module tb_soda_datapath;

  logic       clk = 1'b0;
  logic       rst_n, tc, tw, d;
  logic [7:0] a;
  logic       tm, ovf, chg_pulse, chg_busy, chg_done;
  logic [7:0] tot, chg_left;

  int n_pass = 0;
  int n_total = 0;

  soda_datapath #(.WIDTH(8), .PRICE(25), .CHANGE_UNIT(5)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .tc(tc), .tw(tw), .d(d),
    .tm(tm), .tot(tot), .ovf(ovf), .chg_pulse(chg_pulse),
    .chg_busy(chg_busy), .chg_done(chg_done), .chg_left(chg_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, tc, tw, d;
    logic [7:0] a;
    logic [7:0] tot;
    logic       tm, ovf, pulse, busy, done;
    logic [7:0] left;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic w, input logic dd,
                     input logic [7:0] aa, input logic [7:0] t, input logic m,
                     input logic o, input logic p, input logic b, input logic dn,
                     input logic [7:0] l);
    vec_t v;
    v.rst_n = r; v.tc = c; v.tw = w; v.d = dd; v.a = aa;
    v.tot = t; v.tm = m; v.ovf = o; v.pulse = p; v.busy = b; v.done = dn; v.left = l;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, tot, tm, ovf, chg_pulse, chg_busy, chg_done, chg_left};
  endfunction

  int cycles, pulses, dones, bad;
  logic prev;

  initial begin
    rst_n = 1'b0; tc = 1'b0; tw = 1'b0; d = 1'b0; a = 8'd0;

    //  rst tc tw d  a    tot tm ovf p b dn left
    add(0, 0, 1, 0, 10,   0,  0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 10,   0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 10,  10,  0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 10,  20,  0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 10,  30,  1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0,  0,   0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 25,  25,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1,  0,  25,  1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 19; i++)
      add(1, 0, 0, 1, 0, 25, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0,  0,   0,  0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 37,  37,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1,  0,  37,  1, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1,  0,  37,  1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1,  0,  37,  1, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1,  0,  37,  1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1,  0,  37,  1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1,  0,  37,  1, 0, 0, 0, 0, 2);
    add(1, 0, 1, 1, 10,  37,  1, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0,  0,   0,  0, 0, 0, 0, 0, 2);
    add(1, 0, 1, 0, 20,  20,  0, 0, 0, 0, 0, 2);
    add(1, 1, 1, 0, 10,   0,  0, 0, 0, 0, 0, 2);
    add(1, 0, 1, 0, 20,  20,  0, 0, 0, 0, 0, 2);
    add(1, 0, 1, 0, 10,  30,  1, 0, 0, 0, 0, 2);
    add(1, 1, 0, 1,  0,   0,  0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 1,  0,   0,  0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0,  0,   0,  0, 0, 0, 0, 0, 2);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; tc = tbl[i].tc; tw = tbl[i].tw; d = tbl[i].d; a = tbl[i].a;
      step();
      chk($sformatf("row%0d", i), outs(),
          {11'd0, tbl[i].tot, tbl[i].tm, tbl[i].ovf, tbl[i].pulse, tbl[i].busy,
           tbl[i].done, tbl[i].left});
    end

    // Saturation and a long payout
    tc = 1'b0; d = 1'b0; tw = 1'b1; a = 8'd200;
    step();
    chk("sat_first", {23'd0, ovf, tot}, {23'd0, 1'b0, 8'd200});
    step();
    chk("sat_second", {22'd0, tm, ovf, tot}, {22'd0, 1'b1, 1'b1, 8'd255});
    tw = 1'b0; d = 1'b1;
    step();
    cycles = 0; pulses = 0; dones = 0; bad = 0; prev = 1'b0;
    while (chg_busy && cycles < 300) begin
      if (chg_pulse) pulses++;
      if (chg_done) dones++;
      if (chg_pulse && chg_done) bad++;
      if (chg_pulse && prev) bad++;
      prev = chg_pulse;
      step();
      cycles++;
    end
    chk("sat_pay_finished", {31'd0, chg_busy}, 32'd0);
    chk("sat_pay_cycles", cycles, 32'd93);
    chk("sat_pulses", pulses, 32'd46);
    chk("sat_dones", dones, 32'd1);
    chk("sat_overlap", bad, 32'd0);
    chk("sat_left", {24'd0, chg_left}, 32'd0);
    chk("sat_tot_frozen", {24'd0, tot}, 32'd255);
    d = 1'b0; tc = 1'b1;
    step();
    chk("sat_clear", {23'd0, ovf, tot}, 32'd0);
    tc = 1'b0;

    // Abort with tc after the second pulse
    tw = 1'b1; a = 8'd60;
    step();
    chk("abort_tot", {24'd0, tot}, 32'd60);
    tw = 1'b0; d = 1'b1;
    step();
    chk("abort_pulse1", {30'd0, chg_pulse, chg_busy}, 32'd3);
    step();
    step();
    chk("abort_pulse2", {30'd0, chg_pulse, chg_busy}, 32'd3);
    step();
    chk("abort_gap", {30'd0, chg_pulse, chg_busy}, 32'd1);
    tc = 1'b1;
    step();
    chk("abort_state", {21'd0, chg_busy, chg_pulse, chg_done, tot}, 32'd0);
    tc = 1'b0;
    pulses = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (chg_pulse || chg_busy) pulses++;
      if (chg_done) dones++;
    end
    chk("abort_quiet", pulses + dones, 32'd0);
    d = 1'b0;
    step();

    // Reset mid-payout
    tw = 1'b1; a = 8'd60;
    step();
    tw = 1'b0; d = 1'b1;
    step();
    chk("rst_pulse1", {31'd0, chg_pulse}, 32'd1);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("rst_all_zero", outs(), 32'd0);
    rst_n = 1'b1; d = 1'b0;
    step();
    chk("rst_after", outs(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
